// File: rtl/bcd_serial_converter_pkg.sv
// Shared constants for the serial double-dabble converter: FSM encodings,
// the nibble-correction constants and an elaboration-time power-of-ten helper.
package bcd_serial_converter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Used only in constant context to prove the BCD field can hold the input range.
  function automatic longint unsigned pow10(input int n);
    longint unsigned acc;
    acc = 64'd1;
    for (int i = 0; i < n; i++) begin
      acc = acc * 64'd10;
    end
    return acc;
  endfunction

endpackage

// File: rtl/bcd_serial_converter_digit_adjust.sv
// One BCD nibble's add-3 correction, applied before each shift so a value of
// 5..9 carries correctly into the next digit when doubled.
module bcd_digit_adjust
  import bcd_serial_converter_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  // Inputs here are at most 9, so the result never exceeds 4'd12: no carry out.
  assign o_nib = (i_nib >= BCD_ADJ_THRESH) ? (i_nib + BCD_ADJ_ADD) : i_nib;

endmodule

// File: rtl/bcd_serial_converter.sv
// Iterative binary-to-BCD converter: one adjust-and-shift per clock, WIDTH clocks
// per conversion, with the result held on bcd_out until the next completion.
module bcd_serial_converter
  import bcd_serial_converter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam longint unsigned MAX_BIN   = (64'd1 << WIDTH) - 64'd1;
  localparam longint unsigned BCD_RANGE = pow10(DIGITS);

  generate
    if (!(BCD_RANGE > MAX_BIN)) begin : g_range_check
      $error("bcd_serial_converter: DIGITS too small for WIDTH");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [SR_W-1:0]  r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [BCD_W-1:0] r_bcd;
  logic             r_done;

  logic [BCD_W-1:0] w_adj_bcd;
  logic [SR_W-1:0]  w_pre;
  logic [SR_W-1:0]  w_shifted;
  logic             w_last;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_adjust u_adj (
        .i_nib (r_shift[WIDTH + 4*gi +: 4]),
        .o_nib (w_adj_bcd[4*gi +: 4])
      );
    end
  endgenerate

  assign w_pre     = {w_adj_bcd, r_shift[WIDTH-1:0]};
  assign w_shifted = w_pre << 1;
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift <= {{BCD_W{1'b0}}, bin_in};
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_shift <= w_shifted;
          r_cnt   <= r_cnt + 1'b1;
          // Publish the post-shift digits only once, so bcd_out never shows partials.
          if (w_last) begin
            r_bcd   <= w_shifted[SR_W-1 -: BCD_W];
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == ST_SHIFT);
  assign done    = r_done;
  assign bcd_out = r_bcd;

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Randomized and directed checks of bcd_serial_converter against a decimal
// arithmetic reference model.
module tb_bcd_serial_converter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  bcd_serial_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a conversion, scramble bin_in while busy, and wait for done.
  task automatic run_conv(input int v, output int lat, output int busy_n, output logic done_busy);
    start  = 1'b1;
    bin_in = 8'(v);
    tick();
    start  = 1'b0;
    lat    = 1;
    busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      bin_in = 8'($urandom);
      tick();
      lat++;
    end
    done_busy = busy;
  endtask

  int          lat, busy_n, n, ndone, d0;
  logic        db, hold_ok;
  int          perm[256];
  int          dir_vals[6] = '{255, 99, 100, 9, 10, 0};

  initial begin
    reset = 1'b1; start = 1'b0; bin_in = '0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    // Reset wins over a simultaneous start.
    start = 1'b1; bin_in = 8'd77;
    tick();
    check("rst_vs_start", 32'(busy), 32'd0);
    reset = 1'b0; start = 1'b0;
    tick();

    // Zero input: latency and busy length.
    run_conv(0, lat, busy_n, db);
    check("zero_lat", 32'(lat), 32'd9);
    check("zero_busy_n", 32'(busy_n), 32'd8);
    check("zero_done_busy", 32'(db), 32'd0);
    check("zero_bcd", 32'(bcd_out), 32'h000);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);

    foreach (dir_vals[i]) begin
      run_conv(dir_vals[i], lat, busy_n, db);
      check($sformatf("dir_%0d", dir_vals[i]), 32'(bcd_out), 32'(ref_bcd(dir_vals[i])));
      $display("txn dir bin=%0d bcd=%03h lat=%0d", dir_vals[i], bcd_out, lat);
      tick();
    end

    // Start while busy is ignored; bin_in change does not leak in.
    start = 1'b1; bin_in = 8'd37;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; bin_in = 8'd200;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) ndone++;
      tick();
    end
    check("ignore_ndone", 32'(ndone), 32'd1);
    check("ignore_bcd", 32'(bcd_out), 32'h037);
    check("ignore_idle", 32'(busy), 32'd0);

    // Reset mid-conversion aborts with cleared output and no done.
    run_conv(128, lat, busy_n, db);
    check("pre_abort_bcd", 32'(bcd_out), 32'h128);
    tick();
    start = 1'b1; bin_in = 8'd42;
    tick();
    start = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcd_out), 32'h000);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_conv(42, lat, busy_n, db);
    check("after_abort_bcd", 32'(bcd_out), 32'h042);
    tick();

    // Back-to-back with start held high: output holds through the second conversion.
    start = 1'b1; bin_in = 8'd17;
    tick();
    bin_in = 8'd18;
    n = 1;
    while (!done && n < 20) begin tick(); n++; end
    check("b2b_lat1", 32'(n), 32'd9);
    check("b2b_bcd1", 32'(bcd_out), 32'h017);
    tick();
    start = 1'b0;
    n = 1; hold_ok = 1'b1;
    while (!done && n < 20) begin
      if (bcd_out !== 12'h017) hold_ok = 1'b0;
      tick(); n++;
    end
    check("b2b_lat2", 32'(n), 32'd9);
    check("b2b_hold", 32'(hold_ok), 32'd1);
    check("b2b_bcd2", 32'(bcd_out), 32'h018);
    tick();

    // Full sweep in random order, with random idle gaps.
    foreach (perm[i]) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    d0 = done_cnt;
    foreach (perm[i]) begin
      run_conv(perm[i], lat, busy_n, db);
      check($sformatf("sweep_%0d", perm[i]), 32'(bcd_out), 32'(ref_bcd(perm[i])));
      if (lat != 9) check("sweep_lat", 32'(lat), 32'd9);
      $display("txn sweep bin=%0d bcd=%03h lat=%0d", perm[i], bcd_out, lat);
      if ($urandom_range(1, 0) == 1) tick();
    end
    tick(); tick();
    check("sweep_done_count", 32'(done_cnt - d0), 32'd256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_serial_converter.md
Name: bcd_serial_converter

Overview:
- Iterative shift-and-add-3 (double-dabble) binary-to-BCD converter with a start/busy/done handshake.
- Sits between the iteration counter and the seven-segment controller.
- Converts one WIDTH-bit binary value to DIGITS packed BCD nibbles in WIDTH cycles.
- Holds the result stable on its outputs between conversions, so the display scanner never sees partial values.

Parameters:
- WIDTH, 8: bit width of the binary input.
- DIGITS, 3: number of BCD output digits. Elaboration must fail unless 10^DIGITS > 2^WIDTH - 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a conversion; sampled only in IDLE.
- bin_in  in  WIDTH  binary value; captured on the edge that accepts start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when a new result is on bcd_out.
- bcd_out  out  4*DIGITS  packed BCD result. [3:0] = ones, [7:4] = tens, [11:8] = hundreds, and so on.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; busy = 0; done = 0; bcd_out = 0.
  - Shift register and iteration counter cleared.
  - Reset wins over start in the same cycle.
  - Reset asserted mid-conversion aborts it. bcd_out is cleared to 0, not left at the partial value, and no done pulse is issued.
- States:
  - IDLE:
    - busy = 0.
    - If start = 1 at an edge: load {DIGITS*4 zeros, bin_in} into the internal shift register, set iteration counter = 0, go to SHIFT.
  - SHIFT:
    - busy = 1.
    - Each cycle: every BCD nibble >= 5 gets +3, then the whole register shifts left by 1. The add and shift complete in the same cycle.
    - Counter increments each cycle.
    - After the WIDTH-th shift:
      - Load bcd_out from the upper 4*DIGITS bits (post-shift value).
      - Assert done for the next cycle.
      - Return to IDLE.
- Timing: start sampled at edge E0. busy = 1 for cycles 1..WIDTH. In cycle WIDTH+1, done = 1, busy = 0 and bcd_out is valid. For the default, done appears 9 cycles after acceptance.
- Handshake rules:
  - done is high exactly one cycle per completed conversion.
  - start while busy = 1 is ignored; it is not queued.
  - start during the done cycle is accepted, since state is IDLE. This allows back-to-back conversions every WIDTH+1 cycles.
  - bin_in changes after acceptance do not affect the running conversion.
- Output hold: bcd_out changes only at conversion completion or reset. It holds through the whole next conversion.
- Width rules:
  - Internal shift register is 4*DIGITS + WIDTH bits.
  - Iteration counter is clog2(WIDTH+1) bits.
  - Nibble correction is 4-bit; no carry out of a nibble is possible after the +3 adjust.
  - Max input 2^WIDTH - 1 must convert exactly (255 -> 2,5,5).

Decomposition:
- Shared header/package holds:
  - state encodings ST_IDLE = 2'd0 and ST_SHIFT = 2'd1, with 2'd2 and 2'd3 illegal and recovering to IDLE;
  - BCD_ADJ_THRESH = 4'd5;
  - BCD_ADJ_ADD = 4'd3.
- One natural sub-module: bcd_digit_adjust.
  - Combinational: 4-bit nibble in; nibble + 3 out if >= 5, else unchanged.
  - Instantiated DIGITS times via generate.

Test Plan:
- Reset, then start with bin_in = 0 -> done in cycle 9 after acceptance, bcd_out = 12'h000, busy high for exactly 8 cycles.
- bin_in = 255 -> bcd_out = 12'h255. Also 99 -> 12'h099, 100 -> 12'h100, 9 -> 12'h009, 10 -> 12'h010 (digit-carry boundaries).
- Start with bin_in = 37, pulse start again at busy cycle 3 and change bin_in to 200 -> single done, bcd_out = 12'h037, second start ignored.
- Prior result 12'h128, start 42, assert reset in busy cycle 5 -> next cycle busy = 0, bcd_out = 12'h000, no done pulse; a subsequent start 42 yields 12'h042.
- Hold start high continuously with bin_in = 17 then 18 -> done pulses every 9 cycles. bcd_out stays 12'h017 through the entire second conversion, then becomes 12'h018.
- Random sweep of all 256 values against a golden model -> all match; done count equals accepted-start count.
